fifo_core: RTL and testbench
============================

Name: fifo_core

Overview:
- Single-clock synchronous FIFO. Stores DATA_WIDTH-bit words, up to DEPTH entries deep.
- Provides full/empty/count status plus one-cycle overflow/underflow error pulses.
- Sits behind the push/pop handshake of the FIFO interface. It is the storage core that the FIFO top wraps and that the tester drives (push phase, then pop phase).

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16 (W_DEPTH from fifo_pkg), number of entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  word to write; sampled when a push is accepted.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push requested while full.
- underflow  output  1  one-cycle pulse: pop requested while empty.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Write and read pointers cleared; count=0.
  - empty=1, full=0, data_out=0, overflow=0, underflow=0.
  - Memory contents need not be cleared.
  - Reset has priority over push/pop in the same cycle.
  - Reset mid-operation discards all stored data.
- Pointers: $clog2(DEPTH)+1 bits each, with an extra wrap bit.
  - empty when pointers are equal.
  - full when the address bits are equal and the wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^(addr bits+1).
- Status outputs: full, empty and count are combinational from the registered pointers. They reflect state after the last edge.
- Push accepted when push=1 and full=0:
  - mem[wr_ptr addr] <= data_in; wr_ptr increments; addresses wrap from DEPTH-1 to 0.
- Pop accepted when pop=1 and empty=0:
  - data_out <= mem[rd_ptr addr], one cycle of latency (valid after the edge that accepts the pop); rd_ptr increments with wrap.
- Acceptance uses the flags as they stand before the edge.
- Push and pop in the same cycle:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only push is accepted; pop is rejected and underflow pulses.
  - Full: only pop is accepted; push is rejected and overflow pulses.
- Rejected push: memory and pointers unchanged; overflow=1 for exactly the next cycle.
- Rejected pop: data_out holds its previous value; underflow=1 for exactly the next cycle.
- data_out holds its value whenever no pop is accepted.
- Strict FIFO ordering, including across pointer wrap-around.
- No read-during-write bypass is needed, because a read never targets the slot being written in the same cycle.

Test Plan:
- Reset then idle: drive rst=0 for 1 cycle, then rst=1 -> empty=1, full=0, count=0, data_out=0, no error pulses.
- Fill plus overflow: 17 consecutive pushes of 0x00..0x10 with DEPTH=16.
  - After 16 pushes: full=1, count=16.
  - 17th push: overflow pulses for 1 cycle; count stays 16; 0x10 is not stored.
- Drain plus underflow: then 17 consecutive pops.
  - data_out sequence is 0x00..0x0F, each one cycle after its pop.
  - After the 16th pop: empty=1.
  - 17th pop: underflow pulses; data_out holds 0x0F.
- Wrap-around: push 10, pop 10, push 16, pop 16 -> data matches push order across the pointer wrap; full reached with count=16.
- Simultaneous push/pop:
  - At count=5: count stays 5, and the popped word is the oldest.
  - When empty: push accepted, underflow pulses, count=1.
  - When full: pop accepted, overflow pulses, count=15.
- Reset mid-operation: push 8 words, assert rst=0 for 1 cycle -> count=0, empty=1, data_out=0. A following push of 0xAA then pop returns 0xAA.

Source files
------------

// File: rtl/fifo_core.sv
// Single-clock synchronous FIFO with wrap-bit pointers, registered read data
// and one-cycle overflow/underflow pulses.
module fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full;
      underflow <= pop && empty;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_fifo_core.sv
// Directed bench for fifo_core: stimulus queues expected read words,
// a separate monitor compares data_out one cycle after each accepted pop.
module tb_fifo_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  logic       rd_pend = 1'b0;
  logic [7:0] sb [$];

  fifo_core #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop flagged as accepted before an edge yields data after that edge.
  initial begin
    logic       take;
    logic [7:0] exp_d;
    forever begin
      @(posedge clk);
      take = rd_pend;
      if (take) begin
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rd_data: got 0x%0h with no expected word queued", data_out);
        end else begin
          exp_d = sb.pop_front();
          if (data_out !== exp_d) begin
            failures++;
            $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", data_out, exp_d, $time);
          end
        end
      end
    end
  end

  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic exp_pop, input logic [7:0] exp_d);
    push    = p;
    data_in = d;
    pop     = q;
    rd_pend = exp_pop;
    if (exp_pop) sb.push_back(exp_d);
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    rd_pend = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1, base + 8'(i));
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

    // Reset then idle
    idle();
    rst = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    idle();
    chk("idle_empty", empty, 1);
    chk("idle_udf", underflow, 0);

    // Fill plus overflow
    push_n(16, 8'h00);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf_quiet", overflow, 0);
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 16);
    idle();
    chk("ovf_one_cycle", overflow, 0);

    // Drain plus underflow
    pop_n(16, 8'h00);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("udf_pulse", underflow, 1);
    chk("udf_hold_dout", data_out, 8'h0F);
    idle();
    chk("udf_one_cycle", underflow, 0);
    chk("udf_hold_dout2", data_out, 8'h0F);

    // Wrap-around
    push_n(10, 8'h20);
    chk("wrap_count10", count, 10);
    pop_n(10, 8'h20);
    chk("wrap_empty", empty, 1);
    push_n(16, 8'h40);
    chk("wrap_full", full, 1);
    chk("wrap_count16", count, 16);
    pop_n(16, 8'h40);
    chk("wrap_drained", empty, 1);

    // Simultaneous push/pop at count=5
    push_n(5, 8'h60);
    step(1'b1, 8'h65, 1'b1, 1'b1, 8'h60);
    chk("sim_mid_count", count, 5);
    pop_n(5, 8'h61);

    // Simultaneous when empty
    step(1'b1, 8'h70, 1'b1, 1'b0, 8'h00);
    chk("sim_empty_udf", underflow, 1);
    chk("sim_empty_count", count, 1);
    pop_n(1, 8'h70);

    // Simultaneous when full
    push_n(16, 8'h80);
    step(1'b1, 8'h99, 1'b1, 1'b1, 8'h80);
    chk("sim_full_ovf", overflow, 1);
    chk("sim_full_count", count, 15);
    pop_n(15, 8'h81);
    chk("sim_full_drained", empty, 1);

    // Reset mid-operation
    push_n(8, 8'hB0);
    chk("pre_rst_count", count, 8);
    rst = 1'b0;
    step(1'b1, 8'hCC, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_dout", data_out, 0);
    push_n(1, 8'hAA);
    pop_n(1, 8'hAA);
    idle();
    idle();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
